// File: rtl/enc_ctrl_pkg.sv
// Shared state encoding, default parameters and the output-count clamp for encode_job_ctrl.
package enc_ctrl_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      RUN     = 2'd1,
      FETCH   = 2'd2,
      PRESENT = 2'd3
   } enc_ctrl_state_e;

   localparam int DEF_ADDR_WIDTH  = 4;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_WDOG_CYCLES = 4096;

   // The encoder may report more codes than the output RAM can hold.
   function automatic logic [31:0] clamp_count(input logic [31:0] cnt, input logic [31:0] depth);
      return (cnt > depth) ? depth : cnt;
   endfunction

endpackage

// File: rtl/enc_watchdog.sv
// RUN-phase watchdog: expires after WDOG_CYCLES consecutive run cycles without done.
module enc_watchdog
   import enc_ctrl_pkg::*;
#(
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic done,
   output logic expired
);

   localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

   logic [CW-1:0] count;

   // count holds the number of run cycles already completed before this one
   assign expired = run && (count == CW'(WDOG_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!run || done) begin
         count <= '0;
      end else if (!expired) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/encode_job_ctrl.sv
// Load -> run -> drain job sequencer around the encoder and its RAMs.
// Optional RUN watchdog enabled with macro ENC_WATCHDOG_EN.
module encode_job_ctrl
   import enc_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_ram_we,
   output logic [ADDR_WIDTH-1:0] in_ram_addr,
   output logic [DATA_WIDTH-1:0] in_ram_wdata,
   output logic                  enc_cs,
   output logic [ADDR_WIDTH:0]   enc_in_len,
   input  logic                  enc_done,
   input  logic [ADDR_WIDTH:0]   enc_out_count,
   output logic [ADDR_WIDTH-1:0] out_ram_addr,
   input  logic [DATA_WIDTH-1:0] out_ram_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  err_overflow,
   output logic                  err_timeout,
   output logic [1:0]            dbg_state
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [1:0] S_LOAD    = LOAD;
   localparam logic [1:0] S_RUN     = RUN;
   localparam logic [1:0] S_FETCH   = FETCH;
   localparam logic [1:0] S_PRESENT = PRESENT;

   // Both streams use valid/ready: a beat transfers on a rising edge where valid and ready
   // are both high; once out_valid is raised, out_data/out_last hold until out_ready.
   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   cnt;
   logic [ADDR_WIDTH:0]   done_cnt;
   logic                  primed;
   logic                  accept;
   logic                  beat_last;
   logic                  wdog_expired;

   assign in_ready     = rst_n && (state == S_LOAD);
   assign accept       = in_valid && in_ready;
   assign in_ram_we    = accept;
   assign in_ram_addr  = wr_ptr;
   assign in_ram_wdata = accept ? in_data : '0;
   assign beat_last    = in_last || (wr_ptr == ADDR_WIDTH'(DEPTH - 1));
   assign done_cnt     = (ADDR_WIDTH+1)'(clamp_count(32'(enc_out_count), 32'(DEPTH)));

   assign enc_cs    = (state == S_RUN);
   assign busy      = (state != S_LOAD);
   assign out_valid = (state == S_PRESENT);
   assign out_last  = out_valid && ({1'b0, rd_ptr} == cnt - (ADDR_WIDTH+1)'(1));
   assign dbg_state = state;

   // While presenting, the RAM already reads the next word so a refetch needs only one cycle;
   // the first fetch after RUN waits one extra cycle for the read latency.
   always_comb begin
      out_ram_addr = '0;
      if (state == S_PRESENT) out_ram_addr = rd_ptr + ADDR_WIDTH'(1);
      else if (state == S_FETCH) out_ram_addr = rd_ptr;
   end

`ifdef ENC_WATCHDOG_EN
   enc_watchdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (state == S_RUN),
      .done    (enc_done),
      .expired (wdog_expired)
   );
`else
   logic unused_wdog;
   assign unused_wdog  = ^WDOG_CYCLES;
   assign wdog_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_LOAD;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         cnt          <= '0;
         primed       <= 1'b0;
         enc_in_len   <= '0;
         out_data     <= '0;
         err_overflow <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (accept) begin
                  wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
                  enc_in_len <= {1'b0, wr_ptr} + (ADDR_WIDTH+1)'(1);
                  if (wr_ptr == '0) begin
                     err_overflow <= 1'b0;
                     err_timeout  <= 1'b0;
                  end
                  if (!in_last && (wr_ptr == ADDR_WIDTH'(DEPTH - 1))) err_overflow <= 1'b1;
                  if (beat_last) state <= S_RUN;
               end
            end
            S_RUN: begin
               if (enc_done) begin
                  cnt    <= done_cnt;
                  rd_ptr <= '0;
                  primed <= 1'b0;
                  if (done_cnt == '0) begin
                     state      <= S_LOAD;
                     wr_ptr     <= '0;
                     enc_in_len <= '0;
                  end else begin
                     state <= S_FETCH;
                  end
               end else if (wdog_expired) begin
                  err_timeout <= 1'b1;
                  state       <= S_LOAD;
                  wr_ptr      <= '0;
                  rd_ptr      <= '0;
                  enc_in_len  <= '0;
               end
            end
            S_FETCH: begin
               if (primed) begin
                  out_data <= out_ram_rdata;
                  state    <= S_PRESENT;
               end else begin
                  primed <= 1'b1;
               end
            end
            default: begin
               if (out_ready) begin
                  if (out_last) begin
                     state      <= S_LOAD;
                     wr_ptr     <= '0;
                     rd_ptr     <= '0;
                     enc_in_len <= '0;
                  end else begin
                     rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                     primed <= 1'b1;
                     state  <= S_FETCH;
                  end
               end
            end
         endcase
      end
   end

endmodule
